// File: rtl/sub_bytes_serial_if.sv
// Handshake bundle between the AES round controller and the byte-serial
// SubBytes stage.
//   in_valid/in_ready/in_data/in_mode : state delivered to the stage
//   out_valid/out_ready/out_data      : substituted state delivered onward
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high; the producer holds valid and
// its data stable until that edge.
// The master modport is the side that supplies the state and consumes the
// result. The slave modport is the SubBytes stage itself.
interface sub_bytes_serial_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sub_bytes_serial.sv
// Byte-serial SubBytes(+ShiftRows) stage for a low-area AES datapath.
// It accepts a 128-bit state and streams its 16 bytes through a single
// shared S-box, one byte per clock. Each substituted byte is written
// straight to its (Inv)ShiftRows destination.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : sub_bytes_serial_if slave (in_* / out_* handshake)
//   dbg_state : current FSM state (0 IDLE, 1 SUB, 2 DONE)
// Byte k of a state is data[127-8k -: 8], with k = row + 4*col.

// Combinational AES S-box. mode=1 selects the forward S-box and mode=0
// selects the inverse S-box. The S-box is GF(2^8) inversion combined with
// the affine map, so no 256-entry table is needed.
module sub_bytes (
    input  logic [7:0] a,
    input  logic       mode,
    output logic [7:0] z
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 equals x^-1 for nonzero x, and 0 maps to 0 as the cipher requires.
    // 254 = 2+4+...+128, so square repeatedly and accumulate each square.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] inv_in;
    logic [7:0] fwd_y;

    always_comb begin
        inv_in = 8'h00;
        fwd_y  = 8'h00;
        z      = 8'h00;
        if (mode) begin
            fwd_y = gf_inv(a);
            z = fwd_y ^ {fwd_y[6:0], fwd_y[7]} ^ {fwd_y[5:0], fwd_y[7:6]}
                      ^ {fwd_y[4:0], fwd_y[7:5]} ^ {fwd_y[3:0], fwd_y[7:4]} ^ 8'h63;
        end else begin
            inv_in = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
            z = gf_inv(inv_in);
        end
    end
endmodule

module sub_bytes_serial #(
    parameter bit SHIFT_ROWS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    sub_bytes_serial_if.slave bus,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [3:0]   cnt;
    logic         mode_r;
    logic [127:0] src_reg;
    logic [127:0] out_q;
    logic [7:0]   sbox_a;
    logic [7:0]   sbox_z;
    logic [3:0]   dst;
    logic [1:0]   dst_col;

    sub_bytes u_sbox (
        .a    (sbox_a),
        .mode (mode_r),
        .z    (sbox_z)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = SUB;
            end
            SUB: begin
                if (cnt == 4'd15) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Source byte cnt sits at bit offset 8*(15-cnt).
    assign sbox_a = src_reg[{4'd15 - cnt, 3'b000} +: 8];

    // Destination of source byte (r, c). Forward ShiftRows moves the byte
    // left by r columns and InvShiftRows moves it right. The 2-bit column
    // arithmetic supplies the mod-4 wrap.
    always_comb begin
        dst_col = 2'd0;
        dst     = cnt;
        if (SHIFT_ROWS) begin
            dst_col = mode_r ? (cnt[3:2] - cnt[1:0]) : (cnt[3:2] + cnt[1:0]);
            dst     = {dst_col, cnt[1:0]};
        end
    end

    // out_q is written in place as bytes complete. Bytes that have not been
    // written yet keep stale data, but that data is hidden because
    // out_valid stays low until DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 4'd0;
            mode_r  <= 1'b1;
            src_reg <= 128'd0;
            out_q   <= 128'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        src_reg <= bus.in_data;
                        mode_r  <= bus.in_mode;
                        cnt     <= 4'd0;
                    end
                end
                SUB: begin
                    out_q[{4'd15 - dst, 3'b000} +: 8] <= sbox_z;
                    cnt <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_data = out_q;
    assign dbg_state    = state;
endmodule

// File: tb/tb_sub_bytes_serial.sv
// Testbench for sub_bytes_serial. Two instances run in lockstep on the same
// stimulus. One uses ShiftRows placement and the other uses identity
// placement. Results are compared against a table-driven reference of the
// SubBytes/ShiftRows rules and against fixed FIPS-197 vectors.
module tb_sub_bytes_serial;
    logic clk = 1'b0;
    logic rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_mode;
    logic         out_ready;
    logic [1:0]   dbg_sr;
    logic [1:0]   dbg_id;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   fwd_tab [256];
    logic [7:0]   inv_tab [256];
    logic [127:0] exp_q [$];

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    sub_bytes_serial_if if_sr ();
    sub_bytes_serial_if if_id ();

    assign if_sr.in_valid  = in_valid;
    assign if_sr.in_data   = in_data;
    assign if_sr.in_mode   = in_mode;
    assign if_sr.out_ready = out_ready;
    assign if_id.in_valid  = in_valid;
    assign if_id.in_data   = in_data;
    assign if_id.in_mode   = in_mode;
    assign if_id.out_ready = out_ready;

    sub_bytes_serial #(.SHIFT_ROWS(1'b1)) dut_sr (
        .clk       (clk),
        .rst       (rst),
        .bus       (if_sr),
        .dbg_state (dbg_sr)
    );

    sub_bytes_serial #(.SHIFT_ROWS(1'b0)) dut_id (
        .clk       (clk),
        .rst       (rst),
        .bus       (if_id),
        .dbg_state (dbg_id)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] acc;
        acc = 16'd0;
        for (int i = 0; i < 8; i++)
            if (y[i]) acc = acc ^ (16'(x) << i);
        for (int i = 15; i >= 8; i--)
            if (acc[i]) acc = acc ^ (16'h011b << (i - 8));
        return acc[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            fwd_tab[x] = s;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
    endtask

    // out[r][c] = S(in[r][c+r]) for ShiftRows, S(in[r][c-r]) for InvShiftRows.
    function automatic logic [127:0] ref_round(input logic [127:0] d, input bit mode, input bit shift);
        logic [127:0] o;
        logic [7:0]   b;
        int src_c;
        o = 128'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src_c = !shift ? c : (mode ? (c + r) % 4 : (c - r + 4) % 4);
                b = d[127 - 8 * (r + 4 * src_c) -: 8];
                o[127 - 8 * (r + 4 * c) -: 8] = mode ? fwd_tab[b] : inv_tab[b];
            end
        end
        return o;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string tag, output int lat);
        lat = 0;
        while (!if_sr.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'd16);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!if_sr.in_ready && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 128'(if_sr.in_ready), 128'd1);
    endtask

    task automatic pulse_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 128'(if_sr.out_valid), 128'd0);
        check({tag, "_ready_back"}, 128'(if_sr.in_ready), 128'd1);
    endtask

    // One full transfer. Expected values go into the queue at accept time
    // and come out again when the result appears.
    task automatic do_op(input logic [127:0] d, input bit mode, input string tag);
        int lat;
        wait_ready(tag);
        exp_q.push_back(ref_round(d, mode, 1'b1));
        exp_q.push_back(ref_round(d, mode, 1'b0));
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = mode;
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_mode  = ~mode;
        wait_out(tag, lat);
        check({tag, "_sr"}, if_sr.out_data, exp_q.pop_front());
        check({tag, "_id"}, if_id.out_data, exp_q.pop_front());
        check({tag, "_busy"}, 128'(if_sr.in_ready), 128'd0);
        pulse_out(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] bdat;
        logic [127:0] held;
        int lat;

        rst = 1'b1;
        in_valid = 1'b1;
        in_data = FIPS_IN;
        in_mode = 1'b1;
        out_ready = 1'b0;
        build_tables();
        tick();
        tick();
        check("rst_in_ready", 128'(if_sr.in_ready), 128'd1);
        check("rst_out_valid", 128'(if_sr.out_valid), 128'd0);
        check("rst_out_data", if_sr.out_data, 128'd0);
        check("rst_out_data_id", if_id.out_data, 128'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        check("idle_after_rst", 128'(if_sr.in_ready), 128'd1);

        // FIPS-197 vectors in both directions.
        do_op(FIPS_IN, 1'b1, "fips_fwd");
        check("fips_fwd_const", if_sr.out_data, FIPS_OUT);
        do_op(FIPS_OUT, 1'b0, "fips_inv");
        check("fips_inv_const", if_sr.out_data, FIPS_IN);

        // S-box corner cases, checked on the identity instance.
        do_op({16{8'h00}}, 1'b1, "sbox_00");
        check("sbox_00_const", if_id.out_data, {16{8'h63}});
        do_op({16{8'h53}}, 1'b1, "sbox_53");
        check("sbox_53_const", if_id.out_data, {16{8'hed}});
        do_op({16{8'h63}}, 1'b0, "isbox_63");
        check("isbox_63_const", if_id.out_data, {16{8'h00}});

        // Randomized transfers.
        for (int i = 0; i < 16; i++)
            do_op({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), "rand");

        // Backpressure test. A second request is driven while the block is busy.
        bdat = {$urandom, $urandom, $urandom, $urandom};
        wait_ready("bp");
        in_valid = 1'b1;
        in_data  = FIPS_IN;
        in_mode  = 1'b1;
        tick();
        in_data  = bdat;
        in_mode  = 1'b0;
        wait_out("bp_a", lat);
        held = if_sr.out_data;
        check("bp_a_data", held, FIPS_OUT);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_data", if_sr.out_data, FIPS_OUT);
            check("bp_hold_valid", 128'(if_sr.out_valid), 128'd1);
            check("bp_hold_ready", 128'(if_sr.in_ready), 128'd0);
        end
        pulse_out("bp_a");
        tick();
        in_valid = 1'b0;
        wait_out("bp_b", lat);
        check("bp_b_data", if_sr.out_data, ref_round(bdat, 1'b0, 1'b1));
        pulse_out("bp_b");

        // Reset during SUB.
        in_valid = 1'b1;
        in_data  = FIPS_IN;
        in_mode  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 128'(if_sr.out_valid), 128'd0);
        check("midrst_data", if_sr.out_data, 128'd0);
        check("midrst_ready", 128'(if_sr.in_ready), 128'd1);
        do_op(FIPS_IN, 1'b1, "after_rst");
        check("after_rst_const", if_sr.out_data, FIPS_OUT);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
